snake_step_ctrl: RTL and testbench

Game sequencer for the 7-segment snake game. It turns the free-running `clk` into game ticks at a selectable speed and cleans up the two turn buttons. It issues one step command per tick to the snake datapath and handshakes the result (collision or apple). It owns the IDLE/INIT/RUN/OVER game state and drives the `piezo` request pair.

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_step_ctrl_if.sv | 22 ++
 rtl/btn_debounce.sv | 41 ++++
 rtl/snake_step_ctrl.sv | 138 +++++++++++++
 tb/tb_snake_step_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared types and sound codes for the snake game sequencer
package snake_pkg;

    typedef enum logic [1:0] {
        STRAIGHT = 2'b00,
        LEFT     = 2'b01,
        RIGHT    = 2'b10
    } turn_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        INIT = 2'b01,
        RUN  = 2'b10,
        OVER = 2'b11
    } game_state_t;

    localparam logic [1:0] SND_FAIL  = 2'd0;
    localparam logic [1:0] SND_MOVE  = 2'd1;
    localparam logic [1:0] SND_APPLE = 2'd2;

    // At most one pending flag is ever set, so the order here only fixes the encoding.
    function automatic turn_t pend_to_turn(input logic pend_l, input logic pend_r);
        if (pend_l) begin
            return LEFT;
        end
        if (pend_r) begin
            return RIGHT;
        end
        return STRAIGHT;
    endfunction

endpackage

// File: rtl/snake_step_ctrl_if.sv
// rtl/snake_step_ctrl_if.sv - step command / result handshake between sequencer and datapath
interface snake_step_ctrl_if;
    import snake_pkg::*;

    logic  step_req;
    turn_t step_turn;
    logic  init_req;
    logic  step_ack;
    logic  step_collide;
    logic  step_apple;

    modport master (
        output step_req, step_turn, init_req,
        input  step_ack, step_collide, step_apple
    );

    modport slave (
        input  step_req, step_turn, init_req,
        output step_ack, step_collide, step_apple
    );

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - active-low button: 2-flop synchronizer, debounce counter, press pulse
module btn_debounce #(
    parameter int DEB_W = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic fell_o
);
    // The level flips on the (2^DEB_W-1)th consecutive sample that differs from it.
    localparam logic [DEB_W-1:0] LAST = DEB_W'((1 << DEB_W) - 2);

    logic [1:0]       sync_q;
    logic [DEB_W-1:0] cnt_q;
    logic             level_q;
    logic             fell_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            fell_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_i};
            fell_q <= 1'b0;
            if (sync_q[1] == level_q) begin
                cnt_q <= '0;
            end else if (cnt_q == LAST) begin
                level_q <= sync_q[1];
                cnt_q   <= '0;
                fell_q  <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + DEB_W'(1);
            end
        end
    end

    assign fell_o = fell_q;

endmodule

// File: rtl/snake_step_ctrl.sv
// rtl/snake_step_ctrl.sv - game sequencer: tick prescaler, turn latch and IDLE/INIT/RUN/OVER FSM
module snake_step_ctrl
    import snake_pkg::*;
#(
    parameter int N     = 25,
    parameter int DEB_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btL,
    input  logic              btR,
    input  logic              sw1,
    input  logic              speedSw,
    snake_step_ctrl_if.master step,
    output logic              game_over,
    output logic              tick_miss,
    output logic              speakerCall,
    output logic [1:0]        soundCode
);
    logic         fell_l;
    logic         fell_r;
    logic [N-1:0] cnt_q;
    logic [N-1:0] cnt_d;
    logic         msb_q;
    logic         tick;
    logic         take_turn;
    logic         pend_l_q;
    logic         pend_r_q;
    game_state_t  state_q;
    logic         step_req_q;
    turn_t        step_turn_q;
    logic         init_req_q;
    logic         game_over_q;
    logic         tick_miss_q;
    logic         spk_q;
    logic [1:0]   snd_q;

    btn_debounce #(.DEB_W(DEB_W)) u_deb_l (.clk(clk), .rst_n(rst_n), .btn_i(btL), .fell_o(fell_l));
    btn_debounce #(.DEB_W(DEB_W)) u_deb_r (.clk(clk), .rst_n(rst_n), .btn_i(btR), .fell_o(fell_r));

    assign cnt_d     = cnt_q + (speedSw ? N'(2) : N'(1));
    assign tick      = cnt_q[N-1] & ~msb_q;
    assign take_turn = sw1 && (state_q == RUN) && !step_req_q && tick;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
            msb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            msb_q <= cnt_q[N-1];
        end
    end

    // A press in the same cycle as the flags are consumed survives for the next tick.
    always_ff @(posedge clk) begin
        if (!rst_n || state_q == INIT) begin
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
        end else if (fell_l || fell_r) begin
            pend_l_q <= fell_l & ~fell_r;
            pend_r_q <= fell_r & ~fell_l;
        end else if (take_turn) begin
            pend_l_q <= 1'b0;
            pend_r_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            step_req_q  <= 1'b0;
            step_turn_q <= STRAIGHT;
            init_req_q  <= 1'b0;
            game_over_q <= 1'b0;
            tick_miss_q <= 1'b0;
            spk_q       <= 1'b0;
            snd_q       <= SND_MOVE;
        end else begin
            init_req_q <= 1'b0;
            if (!sw1) begin
                state_q     <= IDLE;
                step_req_q  <= 1'b0;
                game_over_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_q    <= INIT;
                        init_req_q <= 1'b1;
                    end
                    INIT: begin
                        state_q     <= RUN;
                        game_over_q <= 1'b0;
                        tick_miss_q <= tick;
                    end
                    RUN: begin
                        if (step_req_q) begin
                            if (tick) begin
                                tick_miss_q <= 1'b1;
                            end
                            if (step.step_ack) begin
                                step_req_q <= 1'b0;
                                spk_q      <= ~spk_q;
                                if (step.step_collide) begin
                                    state_q     <= OVER;
                                    game_over_q <= 1'b1;
                                    snd_q       <= SND_FAIL;
                                end else if (step.step_apple) begin
                                    snd_q <= SND_APPLE;
                                end else begin
                                    snd_q <= SND_MOVE;
                                end
                            end
                        end else if (tick) begin
                            step_req_q  <= 1'b1;
                            step_turn_q <= pend_to_turn(pend_l_q, pend_r_q);
                        end
                    end
                    OVER: begin
                        tick_miss_q <= 1'b0;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign step.step_req  = step_req_q;
    assign step.step_turn = step_turn_q;
    assign step.init_req  = init_req_q;
    assign game_over      = game_over_q;
    assign tick_miss      = tick_miss_q;
    assign speakerCall    = spk_q;
    assign soundCode      = snd_q;

endmodule

// File: tb/tb_snake_step_ctrl.sv
// tb/tb_snake_step_ctrl.sv - self-checking bench: directed sequences, result table, random vs model
module tb_snake_step_ctrl;
    import snake_pkg::*;

    localparam int N     = 6;
    localparam int DEB_W = 2;
    localparam int HALF  = 1 << (N - 1);
    localparam int FULL  = 1 << N;
    localparam int S_IDLE = 0, S_INIT = 1, S_RUN = 2, S_OVER = 3;

    logic       clk = 1'b0;
    logic       rst_n, btL, btR, sw1, speedSw;
    logic       game_over, tick_miss, speakerCall;
    logic [1:0] soundCode;

    snake_step_ctrl_if step_if();

    snake_step_ctrl #(.N(N), .DEB_W(DEB_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btL        (btL),
        .btR        (btR),
        .sw1        (sw1),
        .speedSw    (speedSw),
        .step       (step_if),
        .game_over  (game_over),
        .tick_miss  (tick_miss),
        .speakerCall(speakerCall),
        .soundCode  (soundCode)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         collide;
        bit         apple;
        logic [1:0] snd;
        bit         over;
    } vec_t;

    vec_t vecs[4];
    int   checks = 0;
    int   errors = 0;
    int   cyc_n  = 0;
    int   rise_a, rise_b, highs;
    bit   exp_spk;

    int         m_cnt, m_prev, m_st;
    bit         m_req, m_init, m_over, m_miss, m_spk;
    logic [1:0] m_snd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic wait_step(input string tag);
        int n;
        n = 0;
        while (step_if.step_req !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk({tag, " step_req rise within budget"}, (n < 200), 1);
    endtask

    task automatic ack_step(input bit c, input bit a, input logic [1:0] snd, input bit over, input string tag);
        step_if.step_ack     = 1'b1;
        step_if.step_collide = c;
        step_if.step_apple   = a;
        cyc();
        step_if.step_ack     = 1'b0;
        step_if.step_collide = 1'b0;
        step_if.step_apple   = 1'b0;
        exp_spk = ~exp_spk;
        chk({tag, " step_req drop"}, step_if.step_req, 0);
        chk({tag, " speakerCall"}, speakerCall, exp_spk);
        chk({tag, " soundCode"}, soundCode, snd);
        chk({tag, " game_over"}, game_over, over);
    endtask

    task automatic hold_btn(input bit l, input bit r, input int n);
        btL = ~l;
        btR = ~r;
        repeat (n) cyc();
        btL = 1'b1;
        btR = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " step_req"}, step_if.step_req, 0);
        chk({tag, " step_turn"}, step_if.step_turn, 0);
        chk({tag, " init_req"}, step_if.init_req, 0);
        chk({tag, " game_over"}, game_over, 0);
        chk({tag, " tick_miss"}, tick_miss, 0);
        chk({tag, " speakerCall"}, speakerCall, 0);
        chk({tag, " soundCode"}, soundCode, 1);
    endtask

    // Reference: a tick is the counter value crossing from the lower to the upper half of its range.
    task automatic model_edge();
        bit tick;
        tick   = (m_prev < HALF) && (m_cnt >= HALF);
        m_prev = m_cnt;
        m_cnt  = (m_cnt + (speedSw ? 2 : 1)) % FULL;
        m_init = 1'b0;
        if (!sw1) begin
            m_st   = S_IDLE;
            m_req  = 1'b0;
            m_over = 1'b0;
        end else if (m_st == S_IDLE) begin
            m_st   = S_INIT;
            m_init = 1'b1;
        end else if (m_st == S_INIT) begin
            m_st   = S_RUN;
            m_miss = tick;
        end else if (m_st == S_OVER) begin
            m_miss = 1'b0;
        end else if (!m_req) begin
            m_req = tick;
        end else begin
            m_miss = m_miss | tick;
            if (step_if.step_ack) begin
                m_req = 1'b0;
                m_spk = ~m_spk;
                m_snd = step_if.step_collide ? 2'd0 : (step_if.step_apple ? 2'd2 : 2'd1);
                if (step_if.step_collide) begin
                    m_st   = S_OVER;
                    m_over = 1'b1;
                end
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{collide: 1'b0, apple: 1'b0, snd: 2'd1, over: 1'b0};
        vecs[1] = '{collide: 1'b0, apple: 1'b1, snd: 2'd2, over: 1'b0};
        vecs[2] = '{collide: 1'b0, apple: 1'b1, snd: 2'd2, over: 1'b0};
        vecs[3] = '{collide: 1'b1, apple: 1'b1, snd: 2'd0, over: 1'b1};

        rst_n = 1'b0;
        btL = 1'b1;
        btR = 1'b1;
        sw1 = 1'b1;
        speedSw = 1'b0;
        step_if.step_ack = 1'b0;
        step_if.step_collide = 1'b0;
        step_if.step_apple = 1'b0;
        exp_spk = 1'b0;
        repeat (3) cyc();
        chk_reset_outputs("reset");

        rst_n = 1'b1;
        cyc_n = 0;
        cyc();
        chk("init_req pulse", step_if.init_req, 1);
        cyc();
        chk("init_req single", step_if.init_req, 0);
        wait_step("first");
        chk("first step latency", cyc_n, 33);
        chk("first step_turn", step_if.step_turn, 0);
        rise_a = cyc_n;
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "first ack");

        wait_step("slow period");
        chk("slow tick period", cyc_n - rise_a, 64);
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "slow ack");
        speedSw = 1'b1;
        wait_step("fast a");
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "fast ack a");
        rise_a = cyc_n - 1;
        wait_step("fast b");
        chk("fast tick period", cyc_n - rise_a, 32);
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "fast ack b");

        hold_btn(1'b1, 1'b0, 7);
        wait_step("left");
        chk("left turn", step_if.step_turn, 1);
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "left ack");
        hold_btn(1'b0, 1'b1, 7);
        wait_step("right");
        chk("right turn", step_if.step_turn, 2);
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "right ack");
        hold_btn(1'b1, 1'b0, 7);
        repeat (6) cyc();
        hold_btn(1'b1, 1'b1, 7);
        wait_step("both");
        chk("both pressed straight", step_if.step_turn, 0);
        ack_step(1'b0, 1'b0, 2'd1, 1'b0, "both ack");

        hold_btn(1'b1, 1'b0, 7);
        wait_step("stall");
        chk("stall turn", step_if.step_turn, 1);
        chk("stall miss before", tick_miss, 0);
        repeat (40) cyc();
        chk("stall tick_miss", tick_miss, 1);
        chk("stall step_req held", step_if.step_req, 1);
        chk("stall turn held", step_if.step_turn, 1);
        rst_n = 1'b0;
        cyc();
        chk_reset_outputs("mid-step reset");
        rst_n = 1'b1;
        exp_spk = 1'b0;

        for (int i = 0; i < 4; i++) begin
            wait_step($sformatf("vec%0d", i));
            ack_step(vecs[i].collide, vecs[i].apple, vecs[i].snd, vecs[i].over, $sformatf("vec%0d", i));
        end
        highs = 0;
        repeat (80) begin
            cyc();
            if (step_if.step_req === 1'b1) highs++;
        end
        chk("over no step_req", highs, 0);
        chk("over game_over held", game_over, 1);
        chk("over tick_miss", tick_miss, 0);
        sw1 = 1'b0;
        cyc();
        chk("sw1 off game_over", game_over, 0);
        sw1 = 1'b1;
        cyc();
        chk("restart init_req", step_if.init_req, 1);
        cyc();
        chk("restart init_req end", step_if.init_req, 0);
        chk("restart game_over", game_over, 0);

        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        m_cnt = 0; m_prev = 0; m_st = S_IDLE;
        m_req = 0; m_init = 0; m_over = 0; m_miss = 0; m_spk = 0; m_snd = 2'd1;
        for (int i = 0; i < 4000; i++) begin
            sw1 = ($urandom_range(0, 299) != 0);
            if ($urandom_range(0, 149) == 0) speedSw = ~speedSw;
            step_if.step_ack     = m_req ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 29) == 0);
            step_if.step_collide = ($urandom_range(0, 9) == 0);
            step_if.step_apple   = ($urandom_range(0, 2) == 0);
            cyc();
            model_edge();
            chk($sformatf("random cycle %0d outputs", i),
                {step_if.step_req, step_if.step_turn, step_if.init_req, game_over, tick_miss, speakerCall, soundCode},
                {m_req, 2'b00, m_init, m_over, m_miss, m_spk, m_snd});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
